// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state codes, byte layout and bus levels.
package i2c_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned STATE_W = 4;

  typedef logic [STATE_W-1:0] i2c_state_t;

  // FSM state encoding
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_WR        = 4'd4;
  localparam logic [3:0] ST_RD        = 4'd5;
  localparam logic [3:0] ST_RD_ACK    = 4'd6;
  localparam logic [3:0] ST_IGNORE    = 4'd7;
  localparam logic [3:0] ST_WAIT_STOP = 4'd8;

  // Position of the R/W flag in the address byte (1 = read)
  localparam int unsigned RW_BIT = 0;

  // SDA levels for acknowledge / not-acknowledge
  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

  // True when the upper seven bits of an address byte select this target
  function automatic logic addr_match(input logic [BYTE_W-1:0] addr_byte,
                                      input logic [6:0]        target);
    return addr_byte[BYTE_W-1:1] == target;
  endfunction

endpackage

// File: rtl/i2c_target_regfile_if.sv
// Pin-side and register-side signals of the I2C register-file target.
interface i2c_target_regfile_if
  import i2c_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) ();

  logic              scl_i;
  logic              sda_i;
  logic              sda_oe;
  logic              busy;
  logic              wr_stb;
  logic [IDX_W-1:0]  wr_idx;
  logic [BYTE_W-1:0] wr_byte;
  logic [IDX_W-1:0]  host_idx;
  logic [BYTE_W-1:0] host_data;

  modport slave (
    input  scl_i, sda_i, host_idx,
    output sda_oe, busy, wr_stb, wr_idx, wr_byte, host_data
  );

  modport master (
    output scl_i, sda_i, host_idx,
    input  sda_oe, busy, wr_stb, wr_idx, wr_byte, host_data
  );

endinterface

// File: rtl/i2c_line_filter.sv
// Synchronises one bus line and accepts a level change only after it has
// held for FILT_LEN clocks; emits the filtered level and one-clock edge pulses.
module i2c_line_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic iRST_N,
  input  logic pin_i,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(FILT_LEN + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept_c;

  // Synchronised level differs from the accepted one and has been stable long enough
  assign accept_c = (sync_q[1] != level) && (cnt_q == CNT_W'(FILT_LEN - 1));

  // Two-flop synchroniser; idle bus level is high
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], pin_i};
  end

  // Stability counter, filtered level and edge pulses
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt_q <= '0;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= accept_c &  sync_q[1];
      fall <= accept_c & ~sync_q[1];
      if (sync_q[1] == level || accept_c) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (accept_c) level <= sync_q[1];
    end
  end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file: first written byte sets the
// pointer, following bytes are written or read with auto-increment.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned NREGS       = 16,
  parameter int unsigned FILT_LEN    = 4
) (
  input logic                  clk,
  input logic                  iRST_N,
  i2c_target_regfile_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NREGS);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_state_t        state_q,   state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shreg_q,   shreg_d;
  logic [IDX_W-1:0]  ptr_q,     ptr_d;
  logic              sda_oe_q,  sda_oe_d;
  logic              busy_q,    busy_d;
  logic              wr_stb_q,  wr_stb_d;
  logic [IDX_W-1:0]  wr_idx_q,  wr_idx_d;
  logic [BYTE_W-1:0] wr_byte_q, wr_byte_d;
  logic              reg_we_c;
  logic              start_c, stop_c;
  logic [BYTE_W-1:0] rx_byte_c;
  logic [BYTE_W-1:0] regs_q [NREGS];

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .iRST_N(iRST_N), .pin_i(bus.scl_i),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .iRST_N(iRST_N), .pin_i(bus.sda_i),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  // Bus conditions and the byte formed by shifting in the current SDA level
  assign start_c   = sda_fall & scl_lvl;
  assign stop_c    = sda_rise & scl_lvl;
  assign rx_byte_c = {shreg_q[BYTE_W-2:0], sda_lvl};

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_byte_d = wr_byte_q;
    reg_we_c  = 1'b0;

    if (start_c || stop_c) begin
      // Any START/STOP aborts the current byte and releases the line
      state_d   = start_c ? ST_ADDR : ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise && bit_cnt_q < BIT_W'(8)) begin
            shreg_d   = rx_byte_c;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end else if (scl_fall && bit_cnt_q == BIT_W'(8)) begin
            if (addr_match(shreg_q, TARGET_ADDR)) begin
              sda_oe_d = ~ACK_LVL;
              busy_d   = 1'b1;
              state_d  = ST_ADDR_ACK;
            end else begin
              state_d  = ST_IGNORE;
            end
          end
        end

        ST_ADDR_ACK: begin
          // The fall closing the ACK clock releases ACK; a read drives its MSB at once
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (shreg_q[RW_BIT]) begin
              state_d  = ST_RD;
              shreg_d  = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][BYTE_W-1];
            end else begin
              state_d  = ST_PTR;
              sda_oe_d = 1'b0;
            end
          end
        end

        ST_PTR, ST_WR: begin
          // bit_cnt 0..7 receiving, 8 byte done, 9 inside the ACK clock
          if (scl_rise && bit_cnt_q < BIT_W'(8)) begin
            shreg_d   = rx_byte_c;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(7)) begin
              if (state_q == ST_PTR) begin
                ptr_d = rx_byte_c[IDX_W-1:0];
              end else begin
                reg_we_c  = 1'b1;
                wr_stb_d  = 1'b1;
                wr_idx_d  = ptr_q;
                wr_byte_d = rx_byte_c;
                ptr_d     = ptr_q + IDX_W'(1);
              end
            end
          end else if (scl_fall && bit_cnt_q == BIT_W'(8)) begin
            sda_oe_d  = ~ACK_LVL;
            bit_cnt_d = BIT_W'(9);
          end else if (scl_fall && bit_cnt_q == BIT_W'(9)) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_WR;
          end
        end

        ST_RD: begin
          // shreg holds the outgoing byte; its MSB is the bit on the line
          if (scl_rise && bit_cnt_q < BIT_W'(8)) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end else if (scl_fall && bit_cnt_q != '0) begin
            if (bit_cnt_q == BIT_W'(8)) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_RD_ACK;
            end else begin
              shreg_d  = {shreg_q[BYTE_W-2:0], 1'b0};
              sda_oe_d = ~shreg_q[BYTE_W-2];
            end
          end
        end

        ST_RD_ACK: begin
          // bit_cnt 1 marks an ACK seen; the following fall starts the next byte
          if (scl_rise && bit_cnt_q == '0) begin
            if (sda_lvl == NACK_LVL) begin
              state_d = ST_WAIT_STOP;
            end else begin
              ptr_d     = ptr_q + IDX_W'(1);
              bit_cnt_d = BIT_W'(1);
            end
          end else if (scl_fall && bit_cnt_q == BIT_W'(1)) begin
            state_d   = ST_RD;
            bit_cnt_d = '0;
            shreg_d   = regs_q[ptr_q];
            sda_oe_d  = ~regs_q[ptr_q][BYTE_W-1];
          end
        end

        default: ;
      endcase
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_idx_q  <= wr_idx_d;
      wr_byte_q <= wr_byte_d;
    end
  end

  // Register file, written on the same edge that raises wr_stb
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (reg_we_c) begin
      regs_q[ptr_q] <= rx_byte_c;
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.busy      = busy_q;
  assign bus.wr_stb    = wr_stb_q;
  assign bus.wr_idx    = wr_idx_q;
  assign bus.wr_byte   = wr_byte_q;
  assign bus.host_data = regs_q[bus.host_idx];

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: a bit-level I2C master on a wired-AND SDA,
// checked against an array model of the register file and pointer.
`timescale 1ns/1ps
module tb_i2c_target_regfile;

  localparam int unsigned NREGS = 16;
  localparam int unsigned IDX_W = 4;
  localparam int          Q     = 10;

  logic clk    = 1'b0;
  logic iRST_N = 1'b0;
  logic scl_m  = 1'b1;
  logic sda_m  = 1'b1;
  logic [IDX_W-1:0] host_idx_t = '0;

  i2c_target_regfile_if #(.IDX_W(IDX_W)) bus ();

  assign bus.scl_i    = scl_m;
  assign bus.sda_i    = sda_m & ~bus.sda_oe;
  assign bus.host_idx = host_idx_t;

  i2c_target_regfile #(.TARGET_ADDR(7'h50), .NREGS(NREGS), .FILT_LEN(4)) dut (
    .clk(clk), .iRST_N(iRST_N), .bus(bus)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  m_regs [NREGS];
  int          m_ptr;
  logic [7:0]  wdata [4];
  logic [11:0] wr_q [$];
  logic [11:0] exp_q [$];
  logic        oe_seen = 1'b0;
  logic        oe_prev = 1'b0;
  int          oe_bad  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write-strobe capture and SDA-drive observation
  always @(negedge clk) begin
    if (bus.wr_stb) wr_q.push_back({bus.wr_idx, bus.wr_byte});
    if (bus.sda_oe) oe_seen = 1'b1;
    if (iRST_N && bus.sda_oe !== oe_prev && scl_m) oe_bad++;
    oe_prev = bus.sda_oe;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic i2c_bit(input logic b, output logic s);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(Q);
    #1 s = bus.sda_i;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_at, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      if (i == glitch_at) begin
        scl_m = 1'b1; tick(3);
        scl_m = 1'b0; tick(Q);
      end
      i2c_bit(b[i], s);
    end
    i2c_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic give_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, s);
      d[i] = s;
    end
    i2c_bit(~give_ack, s);
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < int'(NREGS); i++) begin
      host_idx_t = IDX_W'(i);
      @(negedge clk);
      chk({tag, " host_data"}, bus.host_data, m_regs[i]);
    end
  endtask

  task automatic chk_wr(input string tag);
    logic [11:0] g, e;
    chk({tag, " wr count"}, wr_q.size(), exp_q.size());
    while (wr_q.size() > 0 && exp_q.size() > 0) begin
      g = wr_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, " wr idx/byte"}, g, e);
    end
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic do_write(input string tag, input logic [6:0] addr, input logic [7:0] p,
                          input int n, input int glitch_at);
    logic ack, hit;
    hit = (addr == 7'h50);
    oe_seen = 1'b0;
    i2c_start();
    write_byte({addr, 1'b0}, -1, ack);
    chk({tag, " addr ack"}, ack, hit);
    write_byte(p, -1, ack);
    chk({tag, " ptr ack"}, ack, hit);
    if (hit) m_ptr = int'(p) % NREGS;
    for (int k = 0; k < n; k++) begin
      write_byte(wdata[k], (k == 0) ? glitch_at : -1, ack);
      chk({tag, " data ack"}, ack, hit);
      if (hit) begin
        m_regs[m_ptr] = wdata[k];
        exp_q.push_back({IDX_W'(m_ptr), wdata[k]});
        m_ptr = (m_ptr + 1) % NREGS;
      end
    end
    @(negedge clk);
    chk({tag, " busy"}, bus.busy, hit);
    i2c_stop();
    @(negedge clk);
    chk({tag, " busy after stop"}, bus.busy, 1'b0);
    if (!hit) chk({tag, " sda never driven"}, oe_seen, 1'b0);
    chk_wr(tag);
    chk_regs(tag);
  endtask

  task automatic do_read(input string tag, input logic set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      write_byte(8'hA0, -1, ack);
      chk({tag, " addr ack"}, ack, 1'b1);
      write_byte(p, -1, ack);
      chk({tag, " ptr ack"}, ack, 1'b1);
      m_ptr = int'(p) % NREGS;
      i2c_start();
    end
    write_byte(8'hA1, -1, ack);
    chk({tag, " rd addr ack"}, ack, 1'b1);
    for (int k = 0; k < n; k++) begin
      read_byte(k < n - 1, d);
      chk({tag, " rd data"}, d, m_regs[m_ptr]);
      if (k < n - 1) m_ptr = (m_ptr + 1) % NREGS;
    end
    @(negedge clk);
    chk({tag, " released after nack"}, bus.sda_oe, 1'b0);
    chk({tag, " busy"}, bus.busy, 1'b1);
    i2c_stop();
    @(negedge clk);
    chk({tag, " busy after stop"}, bus.busy, 1'b0);
    chk({tag, " no wr"}, wr_q.size(), 0);
  endtask

  initial begin
    logic s, ack;
    logic [7:0] b;
    logic [6:0] a;
    int kind, n;

    for (int i = 0; i < int'(NREGS); i++) m_regs[i] = 8'h00;
    m_ptr = 0;

    // Reset values
    tick(5);
    @(negedge clk);
    chk("rst sda_oe", bus.sda_oe, 1'b0);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst wr_stb", bus.wr_stb, 1'b0);
    chk("rst wr_idx", bus.wr_idx, 0);
    chk("rst wr_byte", bus.wr_byte, 8'h00);
    iRST_N = 1'b1;
    tick(10);
    chk_regs("rst");

    // Basic write and read-back
    wdata[0] = 8'hAA;
    do_write("wr3", 7'h50, 8'h03, 1, -1);
    do_read("rd3", 1'b1, 8'h03, 1);

    // Wrong address
    wdata[0] = 8'h12; wdata[1] = 8'h34;
    do_write("wrong", 7'h51, 8'h05, 2, -1);

    // Pointer wrap on write and read
    wdata[0] = 8'h11; wdata[1] = 8'h22;
    do_write("wrap wr", 7'h50, 8'h0F, 2, -1);
    do_read("wrap rd", 1'b1, 8'h0F, 2);

    // STOP after five data bits: partial byte dropped, pointer kept
    i2c_start();
    write_byte(8'hA0, -1, ack);
    chk("part addr ack", ack, 1'b1);
    write_byte(8'h07, -1, ack);
    chk("part ptr ack", ack, 1'b1);
    m_ptr = 7;
    b = 8'h5A;
    for (int i = 7; i >= 3; i--) i2c_bit(b[i], s);
    i2c_stop();
    chk_wr("part");
    chk_regs("part");
    do_read("retained", 1'b0, 8'h00, 1);

    // Short SCL glitch inside a data byte
    wdata[0] = 8'hC3;
    do_write("glitch", 7'h50, 8'h09, 1, 4);

    // Reset while the address ACK is driven
    i2c_start();
    b = 8'hA0;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
    for (int k = 0; k < 50 && !bus.sda_oe; k++) tick(1);
    chk("ack driven", bus.sda_oe, 1'b1);
    iRST_N = 1'b0;
    #1;
    chk("rst releases sda", bus.sda_oe, 1'b0);
    scl_m = 1'b1; sda_m = 1'b1;
    tick(10);
    iRST_N = 1'b1;
    oe_prev = 1'b0;
    tick(10);
    for (int i = 0; i < int'(NREGS); i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    wr_q.delete();
    chk_regs("post rst");
    wdata[0] = 8'h3C;
    do_write("post rst wr", 7'h50, 8'h02, 1, -1);
    do_read("post rst rd", 1'b1, 8'h02, 1);

    // Randomised transactions
    for (int t = 0; t < 20; t++) begin
      kind = int'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 3));
      b    = 8'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) wdata[k] = 8'($urandom_range(0, 255));
      case (kind)
        0: do_write("rnd wr", 7'h50, b, n, -1);
        1: do_read("rnd rd", 1'b1, b, n);
        2: do_read("rnd rd cont", 1'b0, 8'h00, n);
        default: begin
          a = 7'($urandom_range(0, 127));
          if (a == 7'h50) a = 7'h51;
          do_write("rnd wrong", a, b, 1, -1);
        end
      endcase
    end

    chk("sda_oe stable while scl high", oe_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
